// File: rtl/serial_disp_rx_pkg.sv
// Shared types and default frame widths for the serial display receiver.
// Imported by the receiver top and its testbench.
package serial_disp_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } rx_state_e;

    localparam int SEG_FRAME_BITS = 64;
    localparam int LED_FRAME_BITS = 16;

endpackage

// File: rtl/serial_disp_rx_if.sv
// Serial link from the SPIO/SSeg7_Dev transmitter to the receiver.
// master = transmitter side, slave = receiver side.
interface serial_disp_rx_if;

    logic s_clk;
    logic s_sout;
    logic s_pen;
    logic s_clrn;

    modport master (
        output s_clk,
        output s_sout,
        output s_pen,
        output s_clrn
    );

    modport slave (
        input s_clk,
        input s_sout,
        input s_pen,
        input s_clrn
    );

endinterface

// File: rtl/serial_disp_rx_sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// lvl_o is delayed to line up with rise_o.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic              rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~hist_q;
        end
    end

    assign lvl_o  = hist_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/serial_disp_rx.sv
// Serial display frame receiver: shifts s_sout on s_clk rises, latches
// a frame on s_pen rises and flags frames of the wrong length.
module serial_disp_rx
    import serial_disp_rx_pkg::*;
#(
    parameter int FRAME_BITS  = SEG_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  RSTN,
    serial_disp_rx_if.slave       ser,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] SAT  = CW'(FRAME_BITS + 1);

    logic clk_rise, pen_rise, clrn_lvl;
    logic unused_clk_lvl, unused_pen_lvl, unused_clrn_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_clk (
        .clk(clk), .rst_n(RSTN), .d_i(ser.s_clk),
        .lvl_o(unused_clk_lvl), .rise_o(clk_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_pen (
        .clk(clk), .rst_n(RSTN), .d_i(ser.s_pen),
        .lvl_o(unused_pen_lvl), .rise_o(pen_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_clrn (
        .clk(clk), .rst_n(RSTN), .d_i(ser.s_clrn),
        .lvl_o(clrn_lvl), .rise_o(unused_clrn_rise)
    );

    // One extra flop matches the edge detector's registered output
    logic [SYNC_STAGES:0]  sout_q;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  fv_q, fv_d;
    logic                  fe_q, fe_d;
    rx_state_e             state_q, state_d;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sout_q      <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            fv_q        <= 1'b0;
            fe_q        <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sout_q      <= {sout_q[SYNC_STAGES-1:0], ser.s_sout};
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fv_q        <= fv_d;
            fe_q        <= fe_d;
            state_q     <= state_d;
        end
    end

    // Shift first, then let a same-cycle latch see the post-shift state
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        fv_d        = 1'b0;
        fe_d        = 1'b0;
        if (!clrn_lvl) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            if (clk_rise) begin
                shreg_d = {shreg_q[FRAME_BITS-2:0], sout_q[SYNC_STAGES]};
                if (cnt_q != SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (pen_rise) begin
                if (cnt_d == FULL) begin
                    data_d      = shreg_d;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    fv_d        = 1'b1;
                end else begin
                    fe_d = 1'b1;
                end
                cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d = SHIFT;
        unique case (1'b1)
            (cnt_d == '0): state_d = IDLE;
            (cnt_d > FULL): state_d = OVER;
            default:       state_d = SHIFT;
        endcase
    end

    assign data_out    = data_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_disp_rx.sv
// Randomized bench for serial_disp_rx against a frame-level model.
// Default parameters: 64-bit frames, 2 synchronizer stages.
module tb_serial_disp_rx;
    import serial_disp_rx_pkg::*;

    localparam int FB  = 64;
    localparam int LAT = 2 + 2;

    logic          clk = 1'b0;
    logic          RSTN = 1'b0;
    logic [FB-1:0] data_out;
    logic          frame_valid, frame_err, busy;
    logic [15:0]   frame_cnt;

    serial_disp_rx_if sif ();

    serial_disp_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk(clk), .RSTN(RSTN), .ser(sif),
        .data_out(data_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fv = 0;
    int n_both = 0;

    logic [FB-1:0] ref_sh = '0;
    int            ref_cnt = 0;
    logic [FB-1:0] ref_data = '0;
    logic [15:0]   ref_fcnt = '0;
    int            ref_good = 0;

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (frame_valid) n_fv++;
        if (frame_valid && frame_err) n_both++;
    end

    function automatic void m_shift(input logic b);
        ref_sh  = {ref_sh[FB-2:0], b};
        ref_cnt = (ref_cnt > FB) ? FB + 1 : ref_cnt + 1;
    endfunction

    function automatic bit m_latch();
        bit ok;
        ok = (ref_cnt == FB);
        if (ok) begin
            ref_data = ref_sh;
            ref_fcnt = ref_fcnt + 16'd1;
            ref_good++;
        end
        ref_cnt = 0;
        return ok;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sif.s_sout = b;
        repeat (5) @(negedge clk);
        sif.s_clk = 1'b1;
        m_shift(b);
        repeat (5) @(negedge clk);
        sif.s_clk = 1'b0;
    endtask

    task automatic send(input logic [71:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // s_pen was raised just before this; watch for the pulse
    task automatic observe(input bit ok, input string tag);
        int lat;
        logic gv, ge;
        lat = 0; gv = 1'b0; ge = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if ((frame_valid || frame_err) && lat == 0) begin
                lat = i; gv = frame_valid; ge = frame_err;
            end
        end
        chk({tag, ".lat"}, lat, LAT);
        chk({tag, ".valid"}, gv, ok);
        chk({tag, ".err"}, ge, !ok);
        @(negedge clk);
        sif.s_pen = 1'b0;
        sif.s_clk = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, ".data"}, data_out, ref_data);
        chk({tag, ".fcnt"}, frame_cnt, ref_fcnt);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    task automatic latch(input string tag);
        bit ok;
        ok = m_latch();
        @(negedge clk);
        sif.s_pen = 1'b1;
        observe(ok, tag);
    endtask

    task automatic sim_latch(input logic b, input string tag);
        bit ok;
        @(negedge clk);
        sif.s_sout = b;
        repeat (5) @(negedge clk);
        m_shift(b);
        ok = m_latch();
        sif.s_clk = 1'b1;
        sif.s_pen = 1'b1;
        observe(ok, tag);
    endtask

    task automatic clear(input int cyc);
        @(negedge clk);
        sif.s_clrn = 1'b0;
        ref_sh  = '0;
        ref_cnt = 0;
        repeat (cyc) @(negedge clk);
        chk("clr.busy", busy, 1'b0);
        sif.s_clrn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [71:0] v;
        int n, k;
        sif.s_clk = 1'b0; sif.s_sout = 1'b0;
        sif.s_pen = 1'b0; sif.s_clrn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.data", data_out, 0);
        chk("rst.fv", frame_valid, 0);
        chk("rst.fe", frame_err, 0);
        chk("rst.busy", busy, 0);
        chk("rst.fcnt", frame_cnt, 0);
        RSTN = 1'b1;
        repeat (6) @(negedge clk);

        send(72'h0123456789ABCDEF, 64);
        chk("good.busy", busy, 1'b1);
        latch("good");
        chk("good.value", data_out, 64'h0123456789ABCDEF);

        send(72'h7EDCBA9876543210, 63);
        latch("short");

        send(72'h1_5555AAAA3333CCCC, 65);
        chk("long.over", dut.state_q == OVER, 1'b1);
        latch("long");

        send(72'h2AAAAAAA, 30);
        clear(10);
        send(72'hFFFF0000FFFF0000, 64);
        latch("clear");
        chk("clear.value", data_out, 64'hFFFF0000FFFF0000);

        send(72'h12_3456789A, 40);
        @(negedge clk);
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst.data", data_out, 0);
        chk("mrst.fcnt", frame_cnt, 0);
        chk("mrst.busy", busy, 0);
        ref_sh = '0; ref_cnt = 0; ref_data = '0; ref_fcnt = '0;
        RSTN = 1'b1;
        repeat (6) @(negedge clk);
        send(72'hABCDEF, 24);
        latch("mrst");

        for (int it = 0; it < 16; it++) begin
            v = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: n = 63;
                1: n = 65;
                2: n = $urandom_range(0, 70);
                default: n = 64;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 20);
                send(v, k);
                clear($urandom_range(4, 12));
            end
            send(v, n);
            latch("rand");
        end

        // Preload the counter near wrap instead of sending 65535 frames
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        ref_fcnt = 16'hFFFE;
        repeat (2) @(negedge clk);
        send(72'hDEADBEEFCAFEF00D, 64);
        latch("pre");
        chk("pre.ffff", frame_cnt, 16'hFFFF);
        v = 72'h0F1E2D3C4B5A6978;
        send(v >> 1, 63);
        sim_latch(v[0], "wrap");
        chk("wrap.zero", frame_cnt, 16'h0000);
        chk("wrap.value", data_out, 64'h0F1E2D3C4B5A6978);

        chk("excl", n_both, 0);
        chk("nvalid", n_fv, ref_good);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_disp_rx.md
SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 64, giving the number of bits per frame (64 for the seven-segment chain, 16 for the LED chain).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on each serial input.
REQ-003 clk  in  1  system clock (100 MHz); all state changes on its rising edge.
REQ-004 RSTN  in  1  reset, asynchronous assert, active-low.
REQ-005 s_clk  in  1  serial shift clock from the SPIO/SSeg7_Dev transmitter; asynchronous to clk, with each high and low phase lasting at least 4 clk periods.
REQ-006 s_sout  in  1  serial data, MSB first, stable around the rising edge of s_clk.
REQ-007 s_pen  in  1  latch/parallel-enable strobe; a rising edge ends a frame.
REQ-008 s_clrn  in  1  active-low shift-register clear from the transmitter.
REQ-009 data_out  out  FRAME_BITS  last good latched frame.
REQ-010 frame_valid  out  1  one-cycle pulse when data_out updates.
REQ-011 frame_err  out  1  one-cycle pulse when a latch occurs with a bit count other than FRAME_BITS.
REQ-012 busy  out  1  high while state is not IDLE.
REQ-013 frame_cnt  out  16  count of good frames; wraps from 0xFFFF to 0.

Function
REQ-014 s_clk, s_pen and s_clrn SHALL each pass through a SYNC_STAGES flop synchronizer, then a rising-edge detector.
REQ-015 s_sout SHALL be delayed by the same number of stages, so it is sampled aligned with the s_clk edge.
REQ-016 On each synchronized s_clk rise, the shift register SHALL shift left and take the sampled s_sout into bit 0.
REQ-017 After FRAME_BITS shifts, the first received bit SHALL sit at data_out[FRAME_BITS-1].
REQ-018 The bit counter SHALL increment on each shift and saturate at FRAME_BITS+1.
REQ-019 The state machine SHALL have these states:
- IDLE: count is 0.
- SHIFT: 1 <= count <= FRAME_BITS.
- OVER: count > FRAME_BITS.
REQ-020 The state transitions SHALL be:
- IDLE -> SHIFT on the first shift.
- SHIFT -> OVER on shift number FRAME_BITS+1.
- Any state -> IDLE on a latch or a clear.
REQ-021 While in OVER, the block SHALL keep shifting, so the register retains the last FRAME_BITS bits.
REQ-022 On a synchronized s_pen rise with count == FRAME_BITS, the block SHALL do all of the following in the next cycle:
- copy the shift register to data_out;
- pulse frame_valid;
- increment frame_cnt.
REQ-023 On a synchronized s_pen rise with any other count (including 0), the block SHALL pulse frame_err in the next cycle and leave data_out and frame_cnt unchanged.
REQ-024 Every latch SHALL clear the bit counter; the shift register contents are not cleared by a latch.
REQ-025 While synchronized s_clrn is low, the block SHALL hold the shift register and counter at 0 and the state at IDLE, and SHALL ignore s_clk and s_pen; data_out and frame_cnt are kept.
REQ-026 When s_clk and s_pen edges are detected in the same cycle, the shift SHALL be applied first and the latch SHALL evaluate the post-shift count and data.
REQ-027 Latency SHALL be SYNC_STAGES+2 clk cycles from the s_pen pin rising to the frame_valid/frame_err pulse.
REQ-028 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-029 While RSTN is low, the block SHALL hold all of the following at 0:
- synchronizers and edge-detect history;
- shift register and counter;
- data_out, frame_valid, frame_err, busy, frame_cnt.
REQ-030 While RSTN is low, the state SHALL be IDLE.
REQ-031 After RSTN deasserts in the middle of a frame, the partial frame SHALL be lost, and a following s_pen rise SHALL produce frame_err unless exactly FRAME_BITS new bits arrived.

Structure
REQ-032 The state encoding (IDLE/SHIFT/OVER) and the default frame widths (SEG_FRAME_BITS=64, LED_FRAME_BITS=16) SHALL be defined in a shared package.
REQ-033 The synchronizer plus rising-edge detector SHALL be one sub-module, sync_edge, instantiated once each for s_clk, s_pen and s_clrn.

Verification
REQ-034 Good frame: FRAME_BITS=64, shift 0x0123456789ABCDEF MSB first, then s_pen rise -> data_out=0x0123456789ABCDEF, one frame_valid pulse, frame_cnt=1, busy returns to 0.
REQ-035 Short frame: 63 bits then s_pen -> frame_err pulse, data_out unchanged.
REQ-036 Long frame: 65 bits then s_pen -> frame_err pulse, state passes through OVER.
REQ-037 Clear mid-frame: 30 bits, s_clrn low for 10 cycles, then 64 bits of 0xFFFF0000FFFF0000 and s_pen -> data_out=0xFFFF0000FFFF0000, frame_valid.
REQ-038 Reset mid-frame: 40 bits, RSTN pulse, 24 bits, s_pen -> frame_err, data_out=0, frame_cnt=0.
REQ-039 Wrap and simultaneous edges: preload frame_cnt to 0xFFFF via 65535 good frames, send a final frame whose 64th s_clk rise coincides with the s_pen rise -> frame_valid, frame_cnt=0.
